// File: rtl/pci_ram_loader_if.sv
// Bundles the dword stream arriving from the PCI side and the RAM write port
// driven towards the 8x64 column-read RAM.
interface pci_ram_loader_if;
    logic        dw_valid;
    logic        dw_ready;
    logic [31:0] dw_data;
    logic [3:0]  dw_be_n;
    logic        dw_last;

    logic        rnw;
    logic [2:0]  wa;
    logic [7:0]  be;
    logic [63:0] di;
    logic        din_valid;

    // The loader: consumes dwords, drives the RAM write port.
    modport slave (
        input  dw_valid, dw_data, dw_be_n, dw_last,
        output dw_ready, rnw, wa, be, di, din_valid
    );

    // The PCI source / RAM observer side.
    modport master (
        output dw_valid, dw_data, dw_be_n, dw_last,
        input  dw_ready, rnw, wa, be, di, din_valid
    );
endinterface

// File: rtl/pci_ram_loader.sv
// Packs a burst of 32-bit dwords into 64-bit rows and writes up to 8 rows into
// the column-read RAM, then holds the RAM in read mode until released.
module pci_ram_loader (
    input  logic                    pci_clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    release_i,
    pci_ram_loader_if.slave         bus,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic [3:0]              rows_o,
    output logic [2:0]              state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_WRITE = 3'd3,
        S_FULL  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  wa_q, wa_d;
    logic [3:0]  rows_q, rows_d;
    logic [7:0]  be_q, be_d;
    logic [63:0] di_q, di_d;
    logic        last_q, last_d;
    logic        rnw_q, din_valid_q, busy_q, frame_done_q;
    logic        dw_ready_c;
    logic        hs;

    // Handshake: a dword transfers on a rising edge where dw_valid and dw_ready
    // are both high; dw_ready depends on state only, never on dw_valid.
    always_comb begin
        dw_ready_c = (state_q == S_LO) || (state_q == S_HI);
        hs         = bus.dw_valid & dw_ready_c;
        state_d    = state_q;
        wa_d       = wa_q;
        rows_d     = rows_q;
        be_d       = be_q;
        di_d       = di_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LO;
                    wa_d    = 3'd0;
                    rows_d  = 4'd0;
                end
            end
            S_LO: begin
                if (hs) begin
                    di_d[31:0] = bus.dw_data;
                    be_d[3:0]  = bus.dw_be_n;
                    last_d     = bus.dw_last;
                    if (bus.dw_last) begin
                        // Lone low dword: upper half is written as zero but masked off.
                        be_d[7:4]   = 4'hF;
                        di_d[63:32] = 32'h0;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (hs) begin
                    di_d[63:32] = bus.dw_data;
                    be_d[7:4]   = bus.dw_be_n;
                    last_d      = bus.dw_last;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                rows_d = rows_q + 4'd1;
                if (last_q || (rows_q == 4'd7)) begin
                    state_d = S_FULL;
                end else begin
                    wa_d    = wa_q + 3'd1;
                    state_d = S_LO;
                end
            end
            S_FULL: begin
                if (release_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pci_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wa_q         <= 3'd0;
            rows_q       <= 4'd0;
            be_q         <= 8'hFF;
            di_q         <= 64'h0;
            last_q       <= 1'b0;
            rnw_q        <= 1'b0;
            din_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wa_q         <= wa_d;
            rows_q       <= rows_d;
            be_q         <= be_d;
            di_q         <= di_d;
            last_q       <= last_d;
            // Status outputs are registered from the next state so they line up with it.
            rnw_q        <= (state_d == S_LO) || (state_d == S_HI) || (state_d == S_WRITE);
            din_valid_q  <= (state_d == S_WRITE);
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= (state_d == S_FULL) && (state_q != S_FULL);
        end
    end

    assign bus.dw_ready  = dw_ready_c;
    assign bus.rnw       = rnw_q;
    assign bus.wa        = wa_q;
    assign bus.be        = be_q;
    assign bus.di        = di_q;
    assign bus.din_valid = din_valid_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign rows_o        = rows_q;
    assign state_o       = state_q;

endmodule

// File: doc/pci_ram_loader.md
# pci_ram_loader

PCI-side write sequencer that sits directly upstream of the 8x64 column-read RAM. It accepts a burst of 32-bit dwords with active-low byte enables, packs dword pairs into 64-bit rows, and drives the RAM write port (rnw, wa, be, di, din_valid) on pci_clk. A frame is at most 8 rows. After the frame is written, the block holds the RAM in read mode until the consumer releases it.

## Interface
Parameters: none; the geometry is fixed at 8 rows x 64 bits.
- pci_clk  in  1  sole clock; all state and outputs change on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a new frame at row 0; honoured only in IDLE
- dw_valid  in  1  dword on dw_data/dw_be_n/dw_last is valid
- dw_ready  out  1  loader accepts a dword this cycle
- dw_data  in  32  dword payload
- dw_be_n  in  4  byte enables for the dword, active-low (PCI C/BE# sense)
- dw_last  in  1  marks the final dword of the frame
- release  in  1  consumer has finished reading the frame; honoured only in FULL
- rnw  out  1  RAM port select: 1 = write (RAM uses wa), 0 = read
- wa  out  3  RAM write row address
- be  out  8  RAM byte enables, active-low; be[i] covers di[8i+7:8i]
- di  out  64  RAM write data
- din_valid  out  1  RAM write strobe, one cycle per row
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse on entry to FULL
- rows  out  4  rows written in the current or most recent frame (0..8)

## Operation
States: IDLE, LO, HI, WRITE, FULL.
- IDLE:
  - rnw=0, dw_ready=0.
  - On start, go to LO and clear rows and wa to 0.
- LO: dw_ready=1. On a handshake (dw_valid & dw_ready):
  - di[31:0] <= dw_data, be[3:0] <= dw_be_n.
  - If dw_last: be[7:4] <= 4'hF and di[63:32] <= 0, then go to WRITE.
  - Otherwise go to HI.
- HI: dw_ready=1. On a handshake:
  - di[63:32] <= dw_data, be[7:4] <= dw_be_n.
  - Go to WRITE.
- WRITE: din_valid=1 and dw_ready=0 for exactly one cycle. On exit:
  - rows increments.
  - If the row carried dw_last, or rows reaches 8: go to FULL.
  - Otherwise wa increments and the block returns to LO.
- FULL:
  - rnw=0 and dw_ready=0; frame_done pulses on the entry cycle.
  - On release, go to IDLE. wa and rows hold until the next start.
- rnw is 1 in LO, HI and WRITE, and 0 in IDLE and FULL. While a frame is loading, the RAM read side sees a frozen output.
- An all-ones dw_be_n is legal. The row is still written (strobe issued), but no byte changes.
- When an 8th row completes without dw_last, the frame is truncated there. Dwords offered afterwards see dw_ready=0 and are not consumed.
- start outside IDLE and release outside FULL are ignored.

## Timing
- Reset values: rnw=0, wa=0, be=8'hFF, di=0, din_valid=0, dw_ready=0, busy=0, frame_done=0, rows=0, state IDLE.
- All outputs are registered except dw_ready, which is decoded from state only (no combinational path from dw_valid).
- Latency:
  - start in cycle n → LO in n+1 (dw_ready=1, busy=1, rnw=1).
  - High dword accepted in cycle n → din_valid=1 with a stable row in n+1; the RAM captures the row at the end of n+1.
  - wa updates in n+2.
- Throughput: one row per 3 cycles at best (LO, HI, WRITE); dw_valid gaps stretch LO/HI indefinitely.
- wa is stable throughout every cycle in which din_valid=1; be/di do not change in WRITE.
- frame_done is high in the first FULL cycle only; rnw falls in that same cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately. A partial row is discarded and never strobed. After rst_n rises, state is IDLE.

## Test plan
- Full frame: start, then 16 dwords 0x00000001..0x00000010 with dw_be_n=0, last on the 16th → 8 din_valid pulses with wa 0..7; row k di = {dword 2k+2, dword 2k+1}, be=8'h00; frame_done once; rows=8; rnw=0 in FULL.
- Odd end: start, 3 dwords A,B,C, last on C → row0 = {B,A} with be=8'h00; row1 = {0,C} with be=8'hF0; rows=2; frame_done.
- Truncation: start, 20 dwords, no last → exactly 8 writes; after FULL, dw_ready=0 while dw_valid stays high; rows=8.
- Byte enables and stalls: dw_be_n=4'b1010/4'b0101 with random dw_valid gaps → be=8'h5A on the row; no extra din_valid pulses; wa unchanged during stalls.
- Control corner cases: start in HI ignored; release in LO ignored; release in FULL → IDLE next cycle, busy=0.
- Reset mid-frame: rst_n low in HI after one dword → outputs at reset values asynchronously, no din_valid; a new start then writes from wa=0.
